uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ requesters.
// Illegal configs are consumed and flagged; accepted frames are held stable until the next issue.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned CNT_WIDTH = 16,
  localparam int unsigned IdW      = $clog2(NUM_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ*8-1:0]   req_data_i,
  input  logic [NUM_REQ*5-1:0]   req_cfg_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   tx_valid_o,
  output logic [7:0]             tx_data_o,
  output logic [4:0]             tx_cfg_o,
  input  logic                   tx_ready_i,
  input  logic                   tx_busy_i,
  output logic [IdW-1:0]         grant_id_o,
  output logic                   err_o,
  output logic [IdW-1:0]         err_id_o,
  output logic [CNT_WIDTH-1:0]   frame_cnt_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StStart, StDrain} state_e;

  state_e               state_q;
  logic [IdW-1:0]       rr_ptr_q;
  logic                 tx_valid_q;
  logic [7:0]           tx_data_q;
  logic [4:0]           tx_cfg_q;
  logic [IdW-1:0]       grant_id_q;
  logic                 err_q;
  logic [IdW-1:0]       err_id_q;
  logic [CNT_WIDTH-1:0] frame_cnt_q;

  logic [7:0] data_arr [NUM_REQ];
  logic [4:0] cfg_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data_i[8*g +: 8];
    assign cfg_arr[g]  = req_cfg_i[5*g +: 5];
  end

  logic           found;
  logic [IdW-1:0] winner;
  int             idx;
  logic [IdW-1:0] sel;

  // Scan downward so the lowest offset from rr_ptr_q is written last and wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    sel    = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % int'(NUM_REQ);
      sel = idx[IdW-1:0];
      if (req_valid_i[sel]) begin
        found  = 1'b1;
        winner = sel;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (!rst_i && state_q == StIdle && found) req_ready_o[winner] = 1'b1;
  end

  logic [4:0] win_cfg;
  logic [7:0] win_data;
  logic       cfg_legal;

  assign win_cfg   = cfg_arr[winner];
  assign cfg_legal = (win_cfg[2:1] != 2'b11);
  // Keep only data_code+5 low bits of the payload.
  assign win_data  = data_arr[winner] & (8'hFF >> (2'd3 - win_cfg[4:3]));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_cfg_q    <= '0;
      grant_id_q  <= '0;
      err_q       <= 1'b0;
      err_id_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (found) begin
            rr_ptr_q <= (int'(winner) == int'(NUM_REQ) - 1) ? '0 : winner + 1'b1;
            if (cfg_legal) begin
              tx_data_q  <= win_data;
              tx_cfg_q   <= win_cfg;
              grant_id_q <= winner;
              tx_valid_q <= 1'b1;
              state_q    <= StIssue;
            end else begin
              err_q    <= 1'b1;
              err_id_q <= winner;
            end
          end
        end
        StIssue: begin
          if (tx_ready_i) begin
            tx_valid_q  <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 1'b1;
            state_q     <= tx_busy_i ? StDrain : StStart;
          end
        end
        StStart: if (tx_busy_i) state_q <= StDrain;
        StDrain: if (!tx_busy_i) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_valid_o  = tx_valid_q;
  assign tx_data_o   = tx_data_q;
  assign tx_cfg_o    = tx_cfg_q;
  assign grant_id_o  = grant_id_q;
  assign err_o       = err_q;
  assign err_id_o    = err_id_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected frames are queued when stimulus is driven
// and compared when the arbiter hands a frame to the modelled UART.
module tb_uart_tx_arbiter;

  localparam int unsigned NumReq = 2;
  localparam int unsigned CntW   = 16;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NumReq-1:0] req_valid_i;
  logic [15:0]       req_data_i;
  logic [9:0]        req_cfg_i;
  logic [NumReq-1:0] req_ready_o;
  logic              tx_valid_o;
  logic [7:0]        tx_data_o;
  logic [4:0]        tx_cfg_o;
  logic              tx_ready_i;
  logic              tx_busy_i;
  logic [0:0]        grant_id_o;
  logic              err_o;
  logic [0:0]        err_id_o;
  logic [CntW-1:0]   frame_cnt_o;

  uart_tx_arbiter #(.NUM_REQ(NumReq), .CNT_WIDTH(CntW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_cfg_i   (req_cfg_i),
    .req_ready_o (req_ready_o),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_cfg_o    (tx_cfg_o),
    .tx_ready_i  (tx_ready_i),
    .tx_busy_i   (tx_busy_i),
    .grant_id_o  (grant_id_o),
    .err_o       (err_o),
    .err_id_o    (err_id_o),
    .frame_cnt_o (frame_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] data;
    logic [4:0] cfg;
  } frame_t;

  frame_t exp_q[$];
  int     total    = 0;
  int     bad      = 0;
  int     hs_cnt   = 0;
  int     busy_len = 3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic [4:0] c);
    req_valid_i[i]       = v;
    req_data_i[8*i +: 8] = d;
    req_cfg_i[5*i +: 5]  = c;
  endtask

  task automatic push(input logic [7:0] id, input logic [7:0] d, input logic [4:0] c);
    frame_t f;
    f.id   = id;
    f.data = d;
    f.cfg  = c;
    exp_q.push_back(f);
  endtask

  // Monitor: handshake counting and frame scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (req_ready_o != '0) chk("rdy_1hot", 32'($onehot(req_ready_o)), 32'd1);
      if ((req_valid_i & req_ready_o) != '0) hs_cnt++;
      if (tx_valid_o && tx_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", 32'd1, 32'd0);
        end else begin
          frame_t f;
          f = exp_q.pop_front();
          chk("sb_id", 32'(grant_id_o), 32'(f.id));
          chk("sb_data", 32'(tx_data_o), 32'(f.data));
          chk("sb_cfg", 32'(tx_cfg_o), 32'(f.cfg));
        end
      end
    end
  end

  // UART model: goes busy the cycle after it accepts a frame.
  initial begin
    tx_busy_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_i && tx_valid_o && tx_ready_i) begin
        @(posedge clk);
        #1 tx_busy_i = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 tx_busy_i = 1'b0;
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_txv"}, 32'(tx_valid_o), 32'd0);
    chk({tag, "_txd"}, 32'(tx_data_o), 32'd0);
    chk({tag, "_txc"}, 32'(tx_cfg_o), 32'd0);
    chk({tag, "_gid"}, 32'(grant_id_o), 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_eid"}, 32'(err_id_o), 32'd0);
    chk({tag, "_cnt"}, 32'(frame_cnt_o), 32'd0);
  endtask

  task automatic single(input int i, input logic [7:0] d, input logic [4:0] c,
                        input logic [7:0] exp_d, input string tag);
    cyc();
    set_req(i, 1'b1, d, c);
    push(8'(i), exp_d, c);
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(req_ready_o), 32'(1 << i));
    cyc();
    set_req(i, 1'b0, 8'h00, 5'h00);
    @(negedge clk);
    chk({tag, "_lat"}, 32'(tx_valid_o), 32'd1);
    repeat (12) cyc();
  endtask

  initial begin
    int base;
    int n;
    rst_i       = 1'b1;
    req_valid_i = '1;
    req_data_i  = 16'h2211;
    req_cfg_i   = {5'b11000, 5'b11000};
    tx_ready_i  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 32'(req_ready_o), 32'd0);
    chk_reset_vals("rst");
    cyc();
    req_valid_i = '0;
    rst_i       = 1'b0;

    single(0, 8'hA5, 5'b11000, 8'hA5, "single");
    chk("single_cnt", 32'(frame_cnt_o), 32'd1);
    single(1, 8'hFF, 5'b00000, 8'h1F, "mask5");
    single(0, 8'hFF, 5'b10011, 8'h7F, "mask7");
    chk("mask_cnt", 32'(frame_cnt_o), 32'd3);

    // Illegal stop code from requester 1
    cyc();
    set_req(1, 1'b1, 8'h55, 5'b00110);
    @(negedge clk);
    chk("ill_rdy", 32'(req_ready_o), 32'b10);
    cyc();
    set_req(1, 1'b0, 8'h00, 5'h00);
    @(negedge clk);
    chk("ill_err", 32'(err_o), 32'd1);
    chk("ill_eid", 32'(err_id_o), 32'd1);
    chk("ill_txv", 32'(tx_valid_o), 32'd0);
    cyc();
    @(negedge clk);
    chk("ill_err_pulse", 32'(err_o), 32'd0);
    chk("ill_eid_hold", 32'(err_id_o), 32'd1);
    chk("ill_cnt", 32'(frame_cnt_o), 32'd3);

    // Backpressure with requester 1 still contending
    cyc();
    tx_ready_i = 1'b0;
    set_req(0, 1'b1, 8'h3C, 5'b01010);
    set_req(1, 1'b1, 8'h99, 5'b11000);
    push(8'd0, 8'h3C, 5'b01010);
    @(negedge clk);
    chk("bp_rdy", 32'(req_ready_o), 32'b01);
    cyc();
    set_req(0, 1'b0, 8'h00, 5'h00);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_txv", 32'(tx_valid_o), 32'd1);
      chk("bp_txd", 32'(tx_data_o), 32'h3C);
      chk("bp_txc", 32'(tx_cfg_o), 32'b01010);
      chk("bp_rdy0", 32'(req_ready_o), 32'd0);
      cyc();
    end
    req_valid_i = '0;
    tx_ready_i  = 1'b1;
    repeat (12) cyc();

    // Contention after reset: expect 0,1,0,1
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    for (int k = 0; k < 4; k++) push(8'(k % 2), (k % 2 == 0) ? 8'h11 : 8'h22,
                                     (k % 2 == 0) ? 5'b11000 : 5'b11001);
    base = hs_cnt;
    set_req(0, 1'b1, 8'h11, 5'b11000);
    set_req(1, 1'b1, 8'h22, 5'b11001);
    n = 0;
    while (hs_cnt < base + 4 && n < 300) begin
      cyc();
      n++;
    end
    chk("cont_timeout", 32'(n < 300), 32'd1);
    req_valid_i = '0;
    repeat (12) cyc();
    chk("cont_cnt", 32'(frame_cnt_o), 32'd4);

    // Reset while draining a long busy frame
    busy_len = 20;
    set_req(0, 1'b1, 8'h5A, 5'b11000);
    push(8'd0, 8'h5A, 5'b11000);
    cyc();
    set_req(0, 1'b0, 8'h00, 5'h00);
    n = 0;
    while (!tx_busy_i && n < 50) begin
      cyc();
      n++;
    end
    chk("drain_timeout", 32'(n < 50), 32'd1);
    repeat (2) cyc();
    rst_i = 1'b1;
    set_req(0, 1'b1, 8'h5A, 5'b11000);
    set_req(1, 1'b1, 8'h22, 5'b11001);
    @(negedge clk);
    chk("drst_rdy", 32'(req_ready_o), 32'd0);
    cyc();
    rst_i = 1'b0;
    @(negedge clk);
    chk_reset_vals("drst");
    chk("drst_regrant", 32'(req_ready_o), 32'b01);
    push(8'd0, 8'h5A, 5'b11000);
    cyc();
    req_valid_i = '0;
    n = 0;
    while ((tx_busy_i || tx_valid_o) && n < 60) begin
      cyc();
      n++;
    end
    chk("drst_timeout", 32'(n < 60), 32'd1);
    repeat (4) cyc();
    chk("drst_cnt", 32'(frame_cnt_o), 32'd1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
